mdu_unit: RTL and testbench

- Multiply/divide unit beside the EX stage of the pipelined mips core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from EX and holds the architectural HI/LO registers.
- Models multi-cycle latency with a busy counter, so the hazard logic stalls following MDU instructions (MFHI/MFLO/mult/div) while an operation runs.
- MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/mips_mdu_pkg.sv | 28 ++
 rtl/mdu_unit.sv | 163 ++++++++++++++++
 tb/tb_mdu_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mips_mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings,
// controller state type and operation classification.
package mips_mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // Multi-cycle operations: the ones that occupy the unit and raise busy.
  function automatic logic is_md_long(input logic [2:0] op);
    logic long_op;
    long_op = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: long_op = 1'b1;
      default:                            long_op = 1'b0;
    endcase
    return long_op;
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO. Results are computed at
// accept, held as pending, and committed after a fixed busy latency.
module mdu_unit
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  // Handshake: start is a one-cycle request; it is taken only when busy==0.
  // Requests made while busy are dropped, so the issuer must honour stall.
  md_state_e        state;
  md_state_e        state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_wr;

  logic             accept;
  logic             accept_long;
  logic             done;

  assign busy        = (state == RUN);
  assign stall       = busy | (start & is_md_long(op));
  assign accept      = start & ~busy;
  assign accept_long = accept & is_md_long(op);
  assign done        = (state == RUN) && (count == '0);

  // Arithmetic datapath
  logic [2*WIDTH-1:0] sprod;
  logic [2*WIDTH-1:0] uprod;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   uquo;
  logic [WIDTH-1:0]   urem;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_mag_safe;
  logic [WIDTH-1:0]   sq_mag;
  logic [WIDTH-1:0]   sr_mag;
  logic [WIDTH-1:0]   squo;
  logic [WIDTH-1:0]   srem;

  assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Divisor forced nonzero so the divider never sees zero; the result is
  // discarded anyway when b==0.
  assign b_safe = (b == '0) ? WIDTH'(1) : b;
  assign uquo   = a / b_safe;
  assign urem   = a % b_safe;

  // Signed divide on magnitudes. The most negative dividend over -1 falls
  // out naturally: magnitude 2^(W-1) / 1 keeps the same bit pattern, rem 0.
  assign a_neg      = a[WIDTH-1];
  assign b_neg      = b[WIDTH-1];
  assign a_mag      = a_neg ? (WIDTH'(0) - a) : a;
  assign b_mag      = b_neg ? (WIDTH'(0) - b) : b;
  assign b_mag_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign sq_mag     = a_mag / b_mag_safe;
  assign sr_mag     = a_mag % b_mag_safe;
  assign squo       = (a_neg ^ b_neg) ? (WIDTH'(0) - sq_mag) : sq_mag;
  assign srem       = a_neg ? (WIDTH'(0) - sr_mag) : sr_mag;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_wr;
  logic [CW-1:0]    res_len;

  always_comb begin
    res_hi  = '0;
    res_lo  = '0;
    res_wr  = 1'b0;
    res_len = CW'(MULT_CYCLES - 1);
    case (op)
      MD_MULT: begin
        {res_hi, res_lo} = sprod;
        res_wr           = 1'b1;
      end
      MD_MULTU: begin
        {res_hi, res_lo} = uprod;
        res_wr           = 1'b1;
      end
      MD_DIV: begin
        res_len = CW'(DIV_CYCLES - 1);
        res_hi  = srem;
        res_lo  = squo;
        res_wr  = (b != '0);
      end
      MD_DIVU: begin
        res_len = CW'(DIV_CYCLES - 1);
        res_hi  = urem;
        res_lo  = uquo;
        res_wr  = (b != '0);
      end
      default: ;
    endcase
  end

  // Controller FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_long) state_next = RUN;
      RUN:  if (count == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter, pending result and architectural HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (accept_long) begin
        count   <= res_len;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
      end else if (busy && (count != '0)) begin
        count <= count - CW'(1);
      end

      if (accept && (op == MD_MTHI)) hi <= a;
      if (accept && (op == MD_MTLO)) lo <= a;

      if (done && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: latency, results, divide-by-zero, MTHI/MTLO,
// ignored requests, back-to-back issue and asynchronous reset mid-operation.
module tb_mdu_unit;
  import mips_mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors;
  int checks;

  mdu_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .stall(stall),
    .hi   (hi),
    .lo   (lo)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Count busy cycles (bounded) while checking stall tracks busy.
  task automatic count_busy(input string tag, output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      check({tag, "_stall_busy"}, {31'b0, stall}, 32'd1);
      n++;
      @(negedge clk);
    end
  endtask

  // Issue one op for a single cycle, then follow it to completion.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    #1;
    check({tag, "_stall_accept"}, {31'b0, stall}, (exp_cyc > 0) ? 32'd1 : 32'd0);
    @(negedge clk);
    start = 1'b0;
    count_busy(tag, n);
    check({tag, "_busy_cycles"}, n, exp_cyc);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int  n;
    logic late;
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    a      = '0;
    b      = '0;

    #12;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mult",  MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("mthi11", MD_MTHI, 32'h0000_0011, 32'h0, 0, 32'h0000_0011, 32'hFFFF_FFFD);
    run_op("mtlo22", MD_MTLO, 32'h0000_0022, 32'h0, 0, 32'h0000_0011, 32'h0000_0022);
    run_op("divu0",  MD_DIVU, 32'h0000_0007, 32'h0, 10, 32'h0000_0011, 32'h0000_0022);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1;
    op    = MD_MTHI;
    a     = 32'hDEAD_BEEF;
    #1;
    check("mthi_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo_kept", lo, 32'h0000_0022);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    op = MD_MTLO;
    a  = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_hi", hi, 32'hDEAD_BEEF);
    check("mtlo_lo", lo, 32'h1234_5678);
    check("mtlo_busy", {31'b0, busy}, 32'd0);

    run_op("nop6", 3'd6, 32'hAAAA_AAAA, 32'h5, 0, 32'hDEAD_BEEF, 32'h1234_5678);
    run_op("nop7", 3'd7, 32'h5555_5555, 32'h9, 0, 32'hDEAD_BEEF, 32'h1234_5678);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu",    MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("div_pos_neg", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

    // MULT 3x4 with a DIV request held during busy, then MULTU back-to-back
    @(negedge clk);
    start = 1'b1;
    op    = MD_MULT;
    a     = 32'd3;
    b     = 32'd4;
    @(negedge clk);
    op = MD_DIV;
    a  = 32'd100;
    b  = 32'd7;
    count_busy("ign", n);
    check("ign_busy_cycles", n, 32'd5);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd12);
    op = MD_MULTU;
    a  = 32'd5;
    b  = 32'd6;
    #1;
    check("b2b_stall_accept", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_nogap", {31'b0, busy}, 32'd1);
    count_busy("b2b", n);
    check("b2b_busy_cycles", n, 32'd5);
    check("b2b_hi", hi, 32'd0);
    check("b2b_lo", lo, 32'd30);

    // Asynchronous reset in the 4th busy cycle of a DIV
    @(negedge clk);
    start = 1'b1;
    op    = MD_DIV;
    a     = 32'd1000;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_stall", {31'b0, stall}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    late  = 1'b0;
    repeat (15) begin
      @(negedge clk);
      late = late | busy | (hi != 32'd0) | (lo != 32'd0);
    end
    check("no_late_commit", {31'b0, late}, 32'd0);
    run_op("post_rst_mult", MD_MULT, 32'd2, 32'd2, 5, 32'd0, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
